// File: rtl/ear_decoder_if.sv
// Sample bus and recovered-level outputs for the tape input decoder.
// The ADC side drives samples in; the decoder drives the tape level,
// the edge strobe and the half-cycle length back out.
interface ear_decoder_if;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        ear;
    logic        ear_edge;
    logic [15:0] period;
    logic        period_valid;

    modport master (
        output adc_valid, adc_data,
        input  ear, ear_edge, period, period_valid
    );

    modport slave (
        input  adc_valid, adc_data,
        output ear, ear_edge, period, period_valid
    );
endinterface

// File: rtl/ear_decoder.sv
// Tape input recovery: tracks a decaying min/max envelope of the ADC samples,
// slices them with a Schmitt trigger around the envelope midpoint and measures
// each half-cycle length in valid samples.
module ear_decoder #(
    parameter int HYST_SH   = 2,
    parameter int DECAY_SH  = 8,
    parameter int MIN_SWING = 64
) (
    input logic          clock,
    input logic          reset,
    ear_decoder_if.slave bus
);
    localparam logic [11:0] MIN_SWING_W = 12'(MIN_SWING);

    logic [11:0]         max_env;
    logic [11:0]         min_env;
    logic [15:0]         sample_cnt;
    logic [DECAY_SH-1:0] decay_cnt;

    logic [11:0]        span;
    logic [12:0]        sum;
    logic [12:0]        mid;
    logic [11:0]        hyst;
    logic signed [13:0] sample_s;
    logic signed [13:0] hi_th;
    logic signed [13:0] lo_th;
    logic               swing_ok;
    logic               toggle;
    logic               raise;
    logic               lower;
    logic               decay_tick;
    logic [15:0]        cnt_inc;

    // Thresholds come from the envelope as it stood before this sample.
    // Widening to 14-bit signed keeps mid +/- h from wrapping at either rail.
    assign span     = max_env - min_env;
    assign sum      = {1'b0, max_env} + {1'b0, min_env};
    assign mid      = sum >> 1;
    assign hyst     = span >> HYST_SH;
    assign sample_s = $signed({2'b00, bus.adc_data});
    assign hi_th    = $signed({1'b0, mid}) + $signed({2'b00, hyst});
    assign lo_th    = $signed({1'b0, mid}) - $signed({2'b00, hyst});
    assign swing_ok = (span >= MIN_SWING_W);

    // Strict comparisons: a sample sitting exactly on a threshold holds.
    assign toggle = bus.adc_valid && swing_ok &&
                    (bus.ear ? (sample_s < lo_th) : (sample_s > hi_th));

    assign raise      = bus.adc_data > max_env;
    assign lower      = bus.adc_data < min_env;
    // span >= 2 keeps min from crossing max when both sides decay together.
    assign decay_tick = (decay_cnt == {DECAY_SH{1'b1}}) && (span >= 12'd2);
    assign cnt_inc    = (sample_cnt == 16'hFFFF) ? sample_cnt : sample_cnt + 16'd1;

    // Envelope tracking: a new extreme wins over decay for that side.
    always_ff @(posedge clock) begin
        if (reset) begin
            max_env   <= 12'h800;
            min_env   <= 12'h800;
            decay_cnt <= '0;
        end else if (bus.adc_valid) begin
            decay_cnt <= decay_cnt + 1'b1;
            if (raise)
                max_env <= bus.adc_data;
            else if (decay_tick)
                max_env <= max_env - 12'd1;
            if (lower)
                min_env <= bus.adc_data;
            else if (decay_tick)
                min_env <= min_env + 12'd1;
        end
    end

    // Schmitt output, edge strobe and saturating half-cycle length.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.ear          <= 1'b0;
            bus.ear_edge     <= 1'b0;
            bus.period_valid <= 1'b0;
            bus.period       <= '0;
            sample_cnt       <= '0;
        end else begin
            bus.ear_edge     <= 1'b0;
            bus.period_valid <= 1'b0;
            if (bus.adc_valid) begin
                if (toggle) begin
                    bus.ear          <= ~bus.ear;
                    bus.ear_edge     <= 1'b1;
                    bus.period_valid <= 1'b1;
                    bus.period       <= cnt_inc;
                    sample_cnt       <= '0;
                end else begin
                    sample_cnt <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_ear_decoder.sv
// Directed bench for ear_decoder: reset, square wave, squelch, hysteresis,
// decay with period saturation, sparse samples and reset mid half-cycle.
module tb_ear_decoder;
    logic clock = 1'b0;
    logic reset;

    ear_decoder_if bus ();

    ear_decoder #(.HYST_SH(2), .DECAY_SH(6), .MIN_SWING(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          edges;
    int          wide;
    int          pv_mis;
    logic        prev_edge;
    logic [15:0] last_period;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1ns after the edge.
    task automatic step(input logic v, input logic [11:0] d);
        bus.adc_valid = v;
        bus.adc_data  = d;
        @(posedge clock);
        #1;
        if (bus.ear_edge === 1'b1) begin
            edges++;
            last_period = bus.period;
            if (prev_edge === 1'b1) wide++;
        end
        if (bus.ear_edge !== bus.period_valid) pv_mis++;
        prev_edge = bus.ear_edge;
    endtask

    task automatic half(input logic [11:0] d, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, d);
            for (int g = 0; g < gap; g++) step(1'b0, d);
        end
    endtask

    initial begin
        logic [11:0] d;
        int          diff;

        reset         = 1'b1;
        bus.adc_valid = 1'b0;
        bus.adc_data  = 12'h800;
        edges         = 0;
        wide          = 0;
        pv_mis        = 0;
        prev_edge     = 1'b0;
        last_period   = '0;

        // reset held 3 cycles with samples being offered
        step(1'b1, 12'h600);
        step(1'b1, 12'hA00);
        step(1'b1, 12'h600);
        check("rst_ear", 32'(bus.ear), 0);
        check("rst_edge", 32'(bus.ear_edge), 0);
        check("rst_period", 32'(bus.period), 0);
        check("rst_pvalid", 32'(bus.period_valid), 0);
        check("rst_toggles", edges, 0);
        reset = 1'b0;

        // square wave, full rate
        for (int hc = 0; hc < 20; hc++) begin
            d = (hc % 2 == 1) ? 12'hA00 : 12'h600;
            edges = 0;
            half(d, 8, 0);
            if (hc == 0) begin
                check("sq_hc0_edges", edges, 0);
            end else begin
                check("sq_edges", edges, 1);
                check("sq_period", 32'(last_period), (hc == 1) ? 9 : 8);
                check("sq_ear", 32'(bus.ear), hc % 2);
            end
        end
        check("sq_width", wide, 0);
        check("sq_pv_align", pv_mis, 0);

        // hold silence: envelope collapses, ear frozen, counter saturates
        edges = 0;
        for (int i = 0; i < 70000; i++) step(1'b1, 12'h800);
        check("dec_edges", edges, 0);
        check("dec_ear", 32'(bus.ear), 1);
        diff = int'(dut.max_env) - int'(dut.min_env);
        check("dec_span_le1", 32'(diff >= 0 && diff <= 1), 1);
        check("dec_near_mid", 32'(dut.max_env >= 12'h7FF && dut.max_env <= 12'h801), 1);
        edges = 0;
        half(12'h600, 8, 0);
        check("sat_edges", edges, 1);
        check("sat_period", 32'(last_period), 32'hFFFF);
        check("sat_ear", 32'(bus.ear), 0);

        // squelch: span 63 never toggles
        reset = 1'b1;
        step(1'b0, 12'h800);
        reset = 1'b0;
        edges = 0;
        for (int hc = 0; hc < 10; hc++) half((hc % 2 == 1) ? 12'h81F : 12'h7E0, 8, 0);
        check("sq63_edges", edges, 0);
        check("sq63_ear", 32'(bus.ear), 0);

        // hysteresis: envelope 0x600..0xA00, ending low
        reset = 1'b1;
        step(1'b0, 12'h800);
        reset = 1'b0;
        half(12'h600, 8, 0);
        half(12'hA00, 8, 0);
        half(12'h600, 8, 0);
        check("hy_setup_ear", 32'(bus.ear), 0);
        edges = 0;
        step(1'b1, 12'h900);
        check("hy_exact_thr", edges, 0);
        for (int i = 0; i < 100; i++) step(1'b1, ((i / 4) % 2 == 1) ? 12'h880 : 12'h780);
        check("hy_band_edges", edges, 0);
        check("hy_band_ear", 32'(bus.ear), 0);
        step(1'b1, 12'h901);
        check("hy_cross_ear", 32'(bus.ear), 1);
        check("hy_cross_edges", edges, 1);
        step(1'b1, 12'h901);
        check("hy_pulse_1cyc", 32'(bus.ear_edge), 0);

        // sparse samples: one valid in four cycles
        reset = 1'b1;
        step(1'b0, 12'h800);
        reset  = 1'b0;
        wide   = 0;
        pv_mis = 0;
        for (int hc = 0; hc < 6; hc++) begin
            edges = 0;
            half((hc % 2 == 1) ? 12'hA00 : 12'h600, 8, 3);
            if (hc >= 1) begin
                check("gap_edges", edges, 1);
                check("gap_period", 32'(last_period), (hc == 1) ? 9 : 8);
            end
        end
        check("gap_width", wide, 0);

        // reset part-way through a high half-cycle
        half(12'h600, 8, 3);
        half(12'hA00, 4, 3);
        reset = 1'b1;
        step(1'b1, 12'hA00);
        reset = 1'b0;
        check("mid_rst_ear", 32'(bus.ear), 0);
        check("mid_rst_edge", 32'(bus.ear_edge), 0);
        check("mid_rst_period", 32'(bus.period), 0);
        check("mid_rst_pvalid", 32'(bus.period_valid), 0);
        edges = 0;
        half(12'hA00, 4, 3);
        check("post_rst_hc1_edges", edges, 1);
        check("post_rst_hc1_period", 32'(last_period), 2);
        check("post_rst_hc1_ear", 32'(bus.ear), 1);
        edges = 0;
        half(12'h600, 8, 3);
        check("post_rst_hc2_edges", edges, 1);
        check("post_rst_hc2_period", 32'(last_period), 3);
        check("post_rst_hc2_ear", 32'(bus.ear), 0);
        check("gap_width_final", wide, 0);
        check("pv_align_final", pv_mis, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ear_decoder.md
# ear_decoder

Tape-input recovery block for the Lynx 48 core. It takes unsigned 12-bit samples from the board audio ADC and tracks the signal envelope with a decaying min/max pair. A Schmitt trigger around the envelope midpoint turns the samples back into the 1-bit `ear` level the machine's tape port reads. It also reports the length of each half-cycle, measured in samples, for the tape-speed and turbo-load logic. It is the input-side counterpart of the audio mixer, which drives `ear` out to the speaker.

## Interface

Parameters:
- `HYST_SH`, 2: hysteresis is the envelope span shifted right by this amount.
- `DECAY_SH`, 8: the envelope decays one step every 2^DECAY_SH valid samples.
- `MIN_SWING`, 64: span below which the output is frozen (squelch).

Ports:
- `clock` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `adc_valid` in 1: one-cycle strobe; `adc_data` is valid in this cycle.
- `adc_data` in 12: unsigned offset-binary sample; 0x800 is silence.
- `ear` out 1: recovered tape level.
- `edge` out 1: one-cycle pulse when `ear` changes.
- `period` out 16: valid-sample count of the half-cycle just ended, saturating.
- `period_valid` out 1: one-cycle pulse; coincides with `edge`.

## Operation

- Reset values: `max_env` = `min_env` = 0x800; `ear` = 0; `edge` = 0; `period_valid` = 0; `period` = 0; sample counter = 0; decay counter = 0.
- Nothing changes in a cycle with `adc_valid` = 0, except that `edge` and `period_valid` return to 0.

Arithmetic, per valid sample `s`, using register values from before the update:
- span = max_env − min_env (12-bit, never negative).
- mid = (max_env + min_env) >> 1, computed with a 13-bit sum.
- h = span >> HYST_SH.
- Comparisons are done in 14-bit signed arithmetic, so mid ± h never wraps.

Schmitt trigger:
- If span ≥ MIN_SWING and `ear` = 0 and s > mid + h: `ear` goes to 1.
- If span ≥ MIN_SWING and `ear` = 1 and s < mid − h: `ear` goes to 0.
- Otherwise `ear` holds.
- A sample exactly at a threshold does not switch.

Envelope:
- If s > max_env: max_env ← s.
- If s < min_env: min_env ← s.
- The decay counter increments on every valid sample and wraps at 2^DECAY_SH.
- On the wrap sample, if span ≥ 2:
  - max_env decrements, unless that same sample raises it.
  - min_env increments, unless that same sample lowers it.
- A new extreme always takes priority over decay for that envelope.
- Decay never makes min_env exceed max_env.

Period measurement:
- The sample counter increments on each valid sample and saturates at 0xFFFF.
- On the valid sample that toggles `ear`:
  - `period` ← min(counter + 1, 0xFFFF).
  - Counter ← 0.
  - `edge` = `period_valid` = 1 for one cycle.
- The first period after reset counts from reset.

## Timing

- Latency: `ear`, `edge`, `period` and `period_valid` update on the clock edge that samples `adc_valid` = 1. They are visible in the following cycle.
- `edge` and `period_valid` are high for exactly one cycle, even if `adc_valid` is held high continuously.
- Back-to-back valid samples (`adc_valid` high on every cycle) are supported at full rate.
- `period` holds its value between edges.
- Reset in the middle of a measurement discards the counter and the envelope. Output returns to the reset values on the next edge. The envelope must rebuild to at least MIN_SWING before `ear` can toggle.

## Test plan

- Reset:
  - Hold `reset` for 3 cycles while driving `adc_valid`.
  - Then `ear` = 0, `edge` = 0, `period` = 0, `period_valid` = 0, and no toggles are reported.
- Square wave:
  - Send 0x600 and 0xA00 alternately, 8 valid samples each, `adc_valid` high every cycle, 20 half-cycles.
  - After the first two half-cycles: `ear` follows the input, with `ear` = 1 during 0xA00.
  - Each edge: `edge` pulses once and `period` = 8.
- Squelch:
  - Send a square wave of 0x7E0 and 0x81F (span 63).
  - Required: `ear` never toggles, `edge` never pulses.
- Hysteresis:
  - Establish an envelope of 0x600 to 0xA00 (mid 0x800, h 0x100), then inject 100 samples that step between 0x780 and 0x880.
  - Required: no toggles.
  - Then inject 0x901: `ear` = 1 and one `edge` pulse.
- Decay and saturation:
  - After the square wave, hold 0x800 for 70000 valid samples.
  - max_env and min_env converge to within 1 of each other around 0x800.
  - `ear` stays constant.
  - On the next square-wave edge, `period` = 0xFFFF.
- Gaps and reset:
  - Square wave with `adc_valid` high only 1 cycle in 4 → `period` = 8 and each `edge` is still 1 cycle wide.
  - Assert `reset` mid-half-cycle → reset values on the next cycle, and the first two half-cycles afterwards produce no false edges.
